// File: rtl/spike_window_classifier.sv
// Per-channel spike counter over a programmable window of cycles. Each window's
// result (winner, its count, tie flag and total) is offered through a valid/ready slot.
module spike_window_classifier #(
  parameter int COUNT_W = 6,
  parameter int WIN_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [WIN_W-1:0]   window_len,
  input  logic [3:0]         spike_in,
  input  logic               result_ready,
  output logic               result_valid,
  output logic [1:0]         winner,
  output logic [COUNT_W-1:0] winner_count,
  output logic               tie,
  output logic [COUNT_W+1:0] total_count,
  output logic               busy,
  output logic               overflow
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c, input logic s);
    logic [COUNT_W-1:0] r;
    if (s && (c != CNT_MAX)) begin
      r = c + COUNT_W'(1);
    end else begin
      r = c;
    end
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [WIN_W-1:0]   len_q, len_d;
  logic [WIN_W-1:0]   cyc_q, cyc_d;
  logic [COUNT_W-1:0] cnt_q [4];
  logic [COUNT_W-1:0] cnt_d [4];
  logic [COUNT_W-1:0] inc_s [4];
  logic [COUNT_W-1:0] snap_q [4];
  logic [COUNT_W-1:0] snap_d [4];
  logic               snap_pending_q, snap_pending_d;
  logic               snap_fire_s;
  logic [WIN_W-1:0]   last_idx_s;
  logic               last_s;

  logic               result_valid_q, result_valid_d;
  logic [1:0]         winner_q, winner_d;
  logic [COUNT_W-1:0] winner_count_q, winner_count_d;
  logic               tie_q, tie_d;
  logic [COUNT_W+1:0] total_q, total_d;
  logic               busy_q, busy_d;
  logic               overflow_q, overflow_d;

  logic [1:0]         best_idx_s;
  logic [COUNT_W-1:0] best_cnt_s;
  logic [2:0]         eq_n_s;
  logic               tie_s;
  logic [COUNT_W+1:0] total_s;

  // Window length 0 behaves as 1, so the last sampling index is 0 in both cases.
  assign last_idx_s = (len_q == '0) ? '0 : (len_q - WIN_W'(1));
  assign last_s     = (cyc_q == last_idx_s);

  // Saturating per-channel increments for the current sampling edge.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      inc_s[i] = sat_inc(cnt_q[i], spike_in[i]);
    end
  end

  // Window FSM: counting, window-end snapshot and length re-latch.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cyc_d       = cyc_q;
    snap_fire_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i]  = cnt_q[i];
      snap_d[i] = snap_q[i];
    end
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_COUNT;
          len_d   = window_len;
          cyc_d   = '0;
          for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COUNT: begin
        if (!enable) begin
          state_d = S_IDLE;
          cyc_d   = '0;
          for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
          end
        end else if (last_s) begin
          snap_fire_s = 1'b1;
          len_d       = window_len;
          cyc_d       = '0;
          for (int i = 0; i < 4; i++) begin
            snap_d[i] = inc_s[i];
            cnt_d[i]  = '0;
          end
        end else begin
          cyc_d = cyc_q + WIN_W'(1);
          for (int i = 0; i < 4; i++) begin
            cnt_d[i] = inc_s[i];
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Winner search over the snapshot: strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_idx_s = 2'd0;
    best_cnt_s = snap_q[0];
    for (int i = 1; i < 4; i++) begin
      if (snap_q[i] > best_cnt_s) begin
        best_idx_s = 2'(i);
        best_cnt_s = snap_q[i];
      end else begin
        best_idx_s = best_idx_s;
      end
    end
    eq_n_s = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (snap_q[i] == best_cnt_s) begin
        eq_n_s = eq_n_s + 3'd1;
      end else begin
        eq_n_s = eq_n_s;
      end
    end
    tie_s   = (eq_n_s >= 3'd2);
    total_s = {2'b00, snap_q[0]} + {2'b00, snap_q[1]} + {2'b00, snap_q[2]} + {2'b00, snap_q[3]};
  end

  // Result slot: load a pending snapshot if the slot frees up this edge, else drop it.
  always_comb begin
    result_valid_d = result_valid_q;
    winner_d       = winner_q;
    winner_count_d = winner_count_q;
    tie_d          = tie_q;
    total_d        = total_q;
    overflow_d     = overflow_q;
    snap_pending_d = snap_fire_s;
    busy_d         = (state_d == S_COUNT);
    if (snap_pending_q) begin
      if (!result_valid_q || result_ready) begin
        result_valid_d = 1'b1;
        winner_d       = best_idx_s;
        winner_count_d = best_cnt_s;
        tie_d          = tie_s;
        total_d        = total_s;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (result_valid_q && result_ready) begin
      result_valid_d = 1'b0;
    end else begin
      result_valid_d = result_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      len_q          <= '0;
      cyc_q          <= '0;
      snap_pending_q <= 1'b0;
      result_valid_q <= 1'b0;
      winner_q       <= 2'd0;
      winner_count_q <= '0;
      tie_q          <= 1'b0;
      total_q        <= '0;
      busy_q         <= 1'b0;
      overflow_q     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      cyc_q          <= cyc_d;
      snap_pending_q <= snap_pending_d;
      result_valid_q <= result_valid_d;
      winner_q       <= winner_d;
      winner_count_q <= winner_count_d;
      tie_q          <= tie_d;
      total_q        <= total_d;
      busy_q         <= busy_d;
      overflow_q     <= overflow_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]  <= cnt_d[i];
        snap_q[i] <= snap_d[i];
      end
    end
  end

  assign result_valid = result_valid_q;
  assign winner       = winner_q;
  assign winner_count = winner_count_q;
  assign tie          = tie_q;
  assign total_count  = total_q;
  assign busy         = busy_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_spike_window_classifier.sv
// Scoreboard bench for spike_window_classifier: expected window results are queued
// as spikes are driven and compared when the DUT hands a result over.
module tb_spike_window_classifier;
  localparam int CW   = 6;
  localparam int WW   = 8;
  localparam int TW   = CW + 2;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [1:0]    w;
    logic [CW-1:0] wc;
    logic          t;
    logic [TW-1:0] tot;
  } res_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [WW-1:0] window_len;
  logic [3:0]    spike_in;
  logic          result_ready;
  logic          result_valid;
  logic [1:0]    winner;
  logic [CW-1:0] winner_count;
  logic          tie;
  logic [TW-1:0] total_count;
  logic          busy;
  logic          overflow;

  int   checks   = 0;
  int   failures = 0;
  res_t sb_q[$];
  res_t last_res;
  int   acc[4];

  spike_window_classifier #(.COUNT_W(CW), .WIN_W(WW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .window_len(window_len),
    .spike_in(spike_in), .result_ready(result_ready), .result_valid(result_valid),
    .winner(winner), .winner_count(winner_count), .tie(tie),
    .total_count(total_count), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input int a0, input int a1, input int a2, input int a3);
    int   c[4];
    int   best;
    int   n;
    res_t r;
    c[0] = (a0 > CMAX) ? CMAX : a0;
    c[1] = (a1 > CMAX) ? CMAX : a1;
    c[2] = (a2 > CMAX) ? CMAX : a2;
    c[3] = (a3 > CMAX) ? CMAX : a3;
    best = 0;
    for (int i = 1; i < 4; i++) if (c[i] > c[best]) best = i;
    n = 0;
    for (int i = 0; i < 4; i++) if (c[i] == c[best]) n++;
    r.w   = 2'(best);
    r.wc  = CW'(c[best]);
    r.t   = (n > 1);
    r.tot = TW'(c[0] + c[1] + c[2] + c[3]);
    return r;
  endfunction

  // One clock; a result handed over at this edge is popped and compared first.
  task automatic tick();
    res_t got;
    res_t e;
    if (result_valid === 1'b1 && result_ready === 1'b1) begin
      got = {winner, winner_count, tie, total_count};
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got w=%0d cnt=%0d tie=%0d tot=%0d, no result expected",
                 got.w, got.wc, got.t, got.tot);
      end else begin
        e = sb_q.pop_front();
        last_res = got;
        if (got !== e) begin
          failures++;
          $display("FAIL sb_result: got w=%0d cnt=%0d tie=%0d tot=%0d, exp w=%0d cnt=%0d tie=%0d tot=%0d",
                   got.w, got.wc, got.t, got.tot, e.w, e.wc, e.t, e.tot);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_acc();
    for (int i = 0; i < 4; i++) acc[i] = 0;
  endtask

  task automatic sample(input logic [3:0] s);
    spike_in = s;
    for (int i = 0; i < 4; i++) acc[i] += int'(s[i]);
    tick();
  endtask

  task automatic close_window();
    sb_q.push_back(model(acc[0], acc[1], acc[2], acc[3]));
    clear_acc();
  endtask

  task automatic start(input int len);
    window_len = WW'(len);
    enable     = 1'b1;
    spike_in   = 4'b0000;
    clear_acc();
    tick();
  endtask

  task automatic stop();
    enable   = 1'b0;
    spike_in = 4'b0000;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; window_len = 8'd0; spike_in = 4'b0000; result_ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({result_valid, winner, winner_count, tie, total_count, busy, overflow} !== 20'd0) begin
      failures++;
      $display("FAIL reset_values: got v=%b w=%0d cnt=%0d tie=%b tot=%0d busy=%b ovf=%b, exp all 0",
               result_valid, winner, winner_count, tie, total_count, busy, overflow);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    result_ready = 1'b1;
    start(10);
    for (int k = 0; k < 10; k++) sample(4'b0001 | ((k == 2 || k == 5 || k == 7) ? 4'b0100 : 4'b0000));
    close_window();
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_after_last_sample: got v=%b busy=%b, exp v=0 busy=1", result_valid, busy);
    end
    stop();
    checks++;
    if (result_valid !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_valid_rise: got v=%b busy=%b, exp v=1 busy=0", result_valid, busy);
    end
    tick();
    checks++;
    if (result_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_valid_pulse: got v=%b, exp 0", result_valid);
    end
    checks++;
    if (last_res.w !== 2'd0 || last_res.wc !== 6'd10 || last_res.t !== 1'b0 || last_res.tot !== 8'd13) begin
      failures++;
      $display("FAIL basic_values: got w=%0d cnt=%0d tie=%b tot=%0d, exp 0/10/0/13",
               last_res.w, last_res.wc, last_res.t, last_res.tot);
    end
  endtask

  task automatic test_tie();
    result_ready = 1'b1;
    start(4);
    for (int k = 0; k < 4; k++) sample(4'b1010);
    close_window();
    stop();
    tick();
    tick();
    checks++;
    if (last_res.w !== 2'd1 || last_res.wc !== 6'd4 || last_res.t !== 1'b1 || last_res.tot !== 8'd8) begin
      failures++;
      $display("FAIL tie_values: got w=%0d cnt=%0d tie=%b tot=%0d, exp 1/4/1/8",
               last_res.w, last_res.wc, last_res.t, last_res.tot);
    end
  endtask

  task automatic test_len_zero();
    result_ready = 1'b1;
    start(0);
    for (int k = 0; k < 8; k++) begin
      sample(4'b1000);
      close_window();
      if (k >= 1) begin
        checks++;
        if (result_valid !== 1'b1 || winner !== 2'd3 || winner_count !== 6'd1 || overflow !== 1'b0) begin
          failures++;
          $display("FAIL len0_stream: cycle %0d got v=%b w=%0d cnt=%0d ovf=%b, exp v=1 w=3 cnt=1 ovf=0",
                   k, result_valid, winner, winner_count, overflow);
        end
      end
    end
    stop();
    tick();
    tick();
    checks++;
    if (sb_q.size() != 0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL len0_drain: got pending=%0d ovf=%b, exp pending=0 ovf=0", sb_q.size(), overflow);
    end
  endtask

  task automatic test_saturate();
    result_ready = 1'b1;
    start(100);
    for (int k = 0; k < 100; k++) sample(4'b0001);
    close_window();
    stop();
    tick();
    tick();
    checks++;
    if (last_res.wc !== 6'd63 || last_res.tot !== 8'd63 || last_res.w !== 2'd0) begin
      failures++;
      $display("FAIL saturate: got w=%0d cnt=%0d tot=%0d, exp w=0 cnt=63 tot=63",
               last_res.w, last_res.wc, last_res.tot);
    end
  endtask

  task automatic test_back_to_back();
    result_ready = 1'b1;
    start(3);
    window_len = 8'd2;
    for (int k = 0; k < 3; k++) sample(4'($urandom_range(0, 15)));
    close_window();
    for (int w = 0; w < 5; w++) begin
      for (int k = 0; k < 2; k++) sample(4'($urandom_range(0, 15)));
      close_window();
    end
    stop();
    tick();
    tick();
    checks++;
    if (sb_q.size() != 0 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain: got pending=%0d v=%b, exp pending=0 v=0", sb_q.size(), result_valid);
    end
  endtask

  task automatic test_enable_drop();
    result_ready = 1'b1;
    start(8);
    for (int k = 0; k < 4; k++) sample(4'b0011);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL drop_busy_before: got busy=%b, exp 1", busy);
    end
    clear_acc();
    stop();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL drop_busy_after: got busy=%b, exp 0", busy);
    end
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (result_valid !== 1'b0 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL drop_no_result: got v=%b pending=%0d, exp v=0 pending=0", result_valid, sb_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [16:0] held;
    result_ready = 1'b0;
    start(3);
    for (int k = 0; k < 3; k++) sample(4'b0100);
    close_window();
    sample(4'b0001);
    held = {winner, winner_count, tie, total_count};
    checks++;
    if (result_valid !== 1'b1 || held !== {2'd2, 6'd3, 1'b0, 8'd3}) begin
      failures++;
      $display("FAIL bp_first_result: got v=%b res=%h, exp v=1 res=%h", result_valid, held, {2'd2, 6'd3, 1'b0, 8'd3});
    end
    sample(4'b0001);
    sample(4'b0001);
    clear_acc();
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL bp_overflow_early: got ovf=%b, exp 0", overflow);
    end
    stop();
    checks++;
    if (overflow !== 1'b1 || result_valid !== 1'b1 || {winner, winner_count, tie, total_count} !== held) begin
      failures++;
      $display("FAIL bp_drop: got ovf=%b v=%b res=%h, exp ovf=1 v=1 res=%h",
               overflow, result_valid, {winner, winner_count, tie, total_count}, held);
    end
    result_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (result_valid !== 1'b0 || overflow !== 1'b1 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL bp_accept: got v=%b ovf=%b pending=%0d, exp v=0 ovf=1 pending=0",
               result_valid, overflow, sb_q.size());
    end
  endtask

  task automatic test_mid_reset();
    result_ready = 1'b0;
    start(2);
    sample(4'b0001);
    sample(4'b0001);
    sample(4'b0001);
    clear_acc();
    checks++;
    if (result_valid !== 1'b1 || busy !== 1'b1 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL mreset_setup: got v=%b busy=%b ovf=%b, exp 1/1/1", result_valid, busy, overflow);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({result_valid, winner, winner_count, tie, total_count, busy, overflow} !== 20'd0) begin
      failures++;
      $display("FAIL mreset_values: got v=%b w=%0d cnt=%0d tie=%b tot=%0d busy=%b ovf=%b, exp all 0",
               result_valid, winner, winner_count, tie, total_count, busy, overflow);
    end
    reset  = 1'b0;
    enable = 1'b0;
    result_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mreset_quiet: got v=%b busy=%b, exp 0/0", result_valid, busy);
    end
  endtask

  initial begin
    clear_acc();
    test_reset();
    test_basic();
    test_tie();
    test_len_zero();
    test_saturate();
    test_back_to_back();
    test_enable_drop();
    test_backpressure();
    test_mid_reset();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d unconsumed results, exp 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
